seq_divider: RTL
================

Name: seq_divider

Overview:
- Iterative signed integer divider; the inverse operation of the existing combinational 64x64 `multiplier` in the execute stage.
- Computes quotient and remainder of two WIDTH-bit two's-complement operands using one restoring-division bit per clock.
- Uses a start/busy/done handshake so the pipeline controller can stall while a division is in flight.

Parameters:
- WIDTH, 64, operand, quotient and remainder width in bits (must be >= 4)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  signed dividend; captured on the accepting edge
- divisor  input  WIDTH  signed divisor; captured on the accepting edge
- quotient  output  WIDTH  signed quotient, registered
- remainder  output  WIDTH  signed remainder, registered
- busy  output  1  high from the accepting edge until the result edge
- done  output  1  single-cycle pulse when results become valid
- div_by_zero  output  1  divisor was 0; valid with done
- overflow  output  1  dividend = most-negative value and divisor = -1; valid with done

Behaviour:
- Reset (async, rst_n=0): state=IDLE. quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, overflow=0, iteration counter=0. Reset mid-operation aborts the division; no done is produced.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Latch sign flags and magnitudes |dividend| and |divisor| (WIDTH bits, unsigned).
  - Set busy=1 and clear div_by_zero and overflow.
  - Special cases go straight to FIX with precomputed results:
    - divisor=0: quotient=all ones, remainder=dividend, div_by_zero=1.
    - dividend=2^(WIDTH-1) negative and divisor=-1: quotient=dividend, remainder=0, overflow=1.
  - Otherwise load the counter with WIDTH and go to CALC.
- CALC, one restoring step per edge:
  - Shift {rem, quo} left by 1.
  - Trial subtract = rem - |divisor|, computed WIDTH+1 bits wide.
  - If the trial subtract is non-negative, rem takes the difference and quo LSB is 1; else rem is kept and quo LSB is 0.
  - Decrement the counter; after the step where the counter reaches 0, go to FIX.
  - With E0 as the accepting edge, the CALC steps occupy edges E1..E(WIDTH).
- FIX, one edge:
  - Negate quo if the operand signs differ.
  - Negate rem if the dividend is negative (truncating division; matches Verilog / and %).
  - Register quotient and remainder, set done=1 and busy=0, return to IDLE.
- Latency:
  - Normal operation: done visible after edge E(WIDTH+1), i.e. 65 edges after E0 when WIDTH=64.
  - Special cases: done visible after E1.
- Output hold and handshake:
  - done is high for exactly one cycle.
  - Result outputs hold their value until the next FIX.
  - start while busy=1 is ignored; no queuing.
  - start in the cycle done=1 (state already IDLE) is accepted normally.
- Invariant: dividend = quotient*divisor + remainder, and |remainder| < |divisor|, for all non-special cases.

Optional Feature:
- Macro: DIV_SIGNED_SEL_EN.
- Defined:
  - Adds input port is_signed (1 bit), sampled with start.
  - is_signed=0 treats operands as unsigned: no abs or negation, and the overflow case is never flagged.
  - is_signed=1 gives the behaviour above.
- Undefined: the port is absent and the block is always signed.

Decomposition:
- Package div_pkg holds:
  - state enum {IDLE, CALC, FIX}
  - DIV_WIDTH_DEF = 64
  - function cnt_w(width) = $clog2(width+1) for the counter width
- Sub-module div_step (combinational): inputs rem, quo, dvsr; outputs next rem, next quo. Instantiated once in CALC.

Test Plan:
- dividend=7566, divisor=78, start pulse -> busy=1 for 65 cycles, then done pulse with quotient=97, remainder=0, flags=0.
- dividend=-45, divisor=7 -> quotient=-6, remainder=-3.
- dividend=-24878735, divisor=-8793577 -> quotient=2, remainder=-7291581.
- dividend=123, divisor=0 -> done one cycle after start; quotient=64'hFFFF_FFFF_FFFF_FFFF, remainder=123, div_by_zero=1.
- dividend=64'h8000_0000_0000_0000, divisor=-1 -> done one cycle after start; quotient=64'h8000_0000_0000_0000, remainder=0, overflow=1.
- Busy interactions:
  - start held high during busy with different operands -> ignored; first result unchanged.
  - rst_n pulsed low at cycle 30 of a division -> all outputs 0 immediately, no done pulse.
  - start issued afterwards -> correct result.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative signed divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DIV_WIDTH_DEF = 64;

  // Width of a counter that must hold the value 'width' itself.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left and trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, used only while the divider is in CALC.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // The shifted partial remainder is WIDTH+1 bits; since rem < dvsr the true
  // difference always fits, so bit WIDTH is exactly the "negative" flag.
  logic [WIDTH:0] trial;

  // Restore (keep shifted rem) on a negative trial, otherwise take the difference.
  always_comb begin
    trial = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
    if (trial[WIDTH]) begin
      rem_next = {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider (quotient + remainder), one restoring bit per clock; optional DIV_SIGNED_SEL_EN adds is_signed.
// Latency: done after WIDTH+1 edges from the accepting edge; divide-by-zero / overflow after 1 edge.
// Backpressure: start is ignored while busy (no queuing); caller stalls on busy and collects on the done pulse.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef DIV_SIGNED_SEL_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             neg_q, neg_r;

  logic             sgn;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             is_zero, is_ovf;

`ifdef DIV_SIGNED_SEL_EN
  assign sgn = is_signed;
`else
  assign sgn = 1'b1;
`endif

  // Operand classification and magnitudes, used only on the accepting edge.
  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign dvd_neg = sgn & dividend[WIDTH-1];
  assign dvs_neg = sgn & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;
  assign is_zero = (divisor == '0);
  assign is_ovf  = sgn && (dividend == MOST_NEG) && (divisor == '1);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .dvsr     (dvsr),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: special operands skip the iteration and go straight to FIX.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (is_zero || is_ovf) ? FIX : CALC;
      CALC: if (cnt == CW'(1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= is_zero;
            overflow    <= is_ovf && !is_zero;
            dvsr        <= dvs_mag;
            cnt         <= CW'(WIDTH);
            if (is_zero) begin
              // Final values preloaded; FIX must not re-sign them.
              quo   <= '1;
              rem   <= dividend;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (is_ovf) begin
              quo   <= dividend;
              rem   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              quo   <= dvd_mag;
              rem   <= '0;
              neg_q <= dvd_neg ^ dvs_neg;
              neg_r <= dvd_neg;
            end
          end
        end
        CALC: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          // Truncating division: quotient sign from operand signs, remainder follows dividend.
          quotient  <= neg_q ? (~quo + 1'b1) : quo;
          remainder <= neg_r ? (~rem + 1'b1) : rem;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
